// File: rtl/vx_sp_ram_arb_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
// The response entry is sized by the RSP_* widths; the top uses them as its defaults.
package vx_sp_ram_arb_pkg;

  localparam int CREDITS_MAX = 2;
  localparam int RSP_DATAW   = 32;
  localparam int RSP_TAGW    = 8;
  localparam int RSP_IDXW    = 2;

  typedef struct packed {
    logic [RSP_DATAW-1:0] data;
    logic [RSP_TAGW-1:0]  tag;
    logic [RSP_IDXW-1:0]  idx;
  } rsp_entry_t;

  function automatic int log2up(input int v);
    if (v > 1) return $clog2(v);
    else       return 1;
  endfunction

  // Wraps a position that may run up to one full lap past n
  function automatic int rr_wrap(input int a, input int n);
    if (a >= n) return a - n;
    else        return a;
  endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted requester.
module vx_rr_arbiter
  import vx_sp_ram_arb_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int IDXW     = log2up(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  output logic [NUM_REQS-1:0] grant,
  output logic                grant_valid,
  output logic [IDXW-1:0]     grant_index
);

  logic [IDXW-1:0] prio_r;
  logic [IDXW-1:0] cand_s;

  // First requesting position at or after the priority pointer
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_index = '0;
    cand_s      = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      cand_s = IDXW'(rr_wrap(int'(prio_r) + k, NUM_REQS));
      if (!grant_valid && requests[cand_s]) begin
        grant_valid = 1'b1;
        grant_index = cand_s;
      end else begin
        grant_index = grant_index;
      end
    end
    if (grant_valid) grant = NUM_REQS'(1'b1) << grant_index;
    else             grant = '0;
  end

  // Pointer moves only on a grant
  always_ff @(posedge clk) begin
    if (reset)            prio_r <= '0;
    else if (grant_valid) prio_r <= IDXW'(rr_wrap(int'(grant_index) + 1, NUM_REQS));
  end

endmodule

// File: rtl/vx_sp_ram.sv
// Single-port RAM with per-lane write enables and a registered read port.
module vx_sp_ram #(
  parameter int DATAW = 32,
  parameter int SIZE  = 256,
  parameter int WRENW = 4,
  parameter int ADDRW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             read,
  input  logic             write,
  input  logic [WRENW-1:0] wren,
  input  logic [ADDRW-1:0] addr,
  input  logic [DATAW-1:0] wdata,
  output logic [DATAW-1:0] rdata
);

  localparam int LANEW = DATAW / WRENW;

  logic [DATAW-1:0] mem_r [SIZE];
  logic [DATAW-1:0] rdata_r;

  // Lane-masked write; contents are intentionally left unreset
  always_ff @(posedge clk) begin
    if (write) begin
      for (int l = 0; l < WRENW; l++) begin
        if (wren[l]) mem_r[addr][l*LANEW +: LANEW] <= wdata[l*LANEW +: LANEW];
      end
    end
  end

  // Registered read data
  always_ff @(posedge clk) begin
    if (reset)     rdata_r <= '0;
    else if (read) rdata_r <= mem_r[addr];
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/vx_sp_ram_arb.sv
// Credit-limited round-robin arbiter in front of a single-port RAM.
// Stall counter built only with VX_SP_RAM_ARB_PERF_EN defined.
module vx_sp_ram_arb
  import vx_sp_ram_arb_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = RSP_DATAW,
  parameter int SIZE     = 256,
  parameter int WRENW    = 4,
  parameter int TAGW     = RSP_TAGW,
  parameter int ADDRW    = log2up(SIZE)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS-1:0]       req_rw,
  input  logic [NUM_REQS*ADDRW-1:0] req_addr,
  input  logic [NUM_REQS*WRENW-1:0] req_wren,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  input  logic [NUM_REQS*TAGW-1:0]  req_tag,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic [NUM_REQS-1:0]       rsp_valid,
  output logic [DATAW-1:0]          rsp_data,
  output logic [TAGW-1:0]           rsp_tag,
  input  logic [NUM_REQS-1:0]       rsp_ready,
  output logic [31:0]               perf_stalls
);

  localparam int IDXW = log2up(NUM_REQS);

  logic [1:0]          credits_r;
  logic                credit_ok_s;
  logic [NUM_REQS-1:0] eligible_s;
  logic [NUM_REQS-1:0] grant_s;
  logic                grant_valid_s;
  logic [IDXW-1:0]     grant_idx_s;
  logic                rd_fire_s;
  logic                wr_fire_s;
  logic [DATAW-1:0]    ram_rdata_s;

  logic                pend_valid_r;
  logic [TAGW-1:0]     pend_tag_r;
  logic [IDXW-1:0]     pend_idx_r;

  rsp_entry_t          buf_r [CREDITS_MAX];
  logic                wr_ptr_r;
  logic                rd_ptr_r;
  logic [1:0]          count_r;
  rsp_entry_t          head_s;
  logic                rsp_fire_s;

  // Writes never wait; reads need a credit so the response buffer cannot overflow
  assign credit_ok_s = (credits_r != 2'd0);
  assign eligible_s  = req_valid & (req_rw | {NUM_REQS{credit_ok_s}}) & {NUM_REQS{~reset}};

  vx_rr_arbiter #(.NUM_REQS(NUM_REQS), .IDXW(IDXW)) arb (
    .clk         (clk),
    .reset       (reset),
    .requests    (eligible_s),
    .grant       (grant_s),
    .grant_valid (grant_valid_s),
    .grant_index (grant_idx_s)
  );

  assign req_ready = grant_s;
  assign rd_fire_s = grant_valid_s & ~req_rw[grant_idx_s];
  assign wr_fire_s = grant_valid_s &  req_rw[grant_idx_s];

  vx_sp_ram #(.DATAW(DATAW), .SIZE(SIZE), .WRENW(WRENW), .ADDRW(ADDRW)) ram (
    .clk   (clk),
    .reset (reset),
    .read  (rd_fire_s),
    .write (wr_fire_s),
    .wren  (req_wren[grant_idx_s*WRENW +: WRENW]),
    .addr  (req_addr[grant_idx_s*ADDRW +: ADDRW]),
    .wdata (req_data[grant_idx_s*DATAW +: DATAW]),
    .rdata (ram_rdata_s)
  );

  assign head_s     = buf_r[rd_ptr_r];
  assign rsp_fire_s = (count_r != 2'd0) && rsp_ready[head_s.idx];
  assign rsp_data   = head_s.data;
  assign rsp_tag    = head_s.tag;

  // One-hot response valid toward the requester that owns the head entry
  always_comb begin
    if (count_r != 2'd0) rsp_valid = NUM_REQS'(1'b1) << head_s.idx;
    else                 rsp_valid = '0;
  end

  // Read pipeline stage covering the RAM's registered read
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_r <= 1'b0;
      pend_tag_r   <= '0;
      pend_idx_r   <= '0;
    end else begin
      pend_valid_r <= rd_fire_s;
      pend_tag_r   <= req_tag[grant_idx_s*TAGW +: TAGW];
      pend_idx_r   <= grant_idx_s;
    end
  end

  // Response FIFO and credit accounting; a returned credit is usable next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CREDITS_MAX; i++) buf_r[i] <= '0;
      wr_ptr_r  <= 1'b0;
      rd_ptr_r  <= 1'b0;
      count_r   <= 2'd0;
      credits_r <= 2'(CREDITS_MAX);
    end else begin
      if (pend_valid_r) begin
        buf_r[wr_ptr_r] <= '{data: ram_rdata_s, tag: pend_tag_r, idx: pend_idx_r};
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (rsp_fire_s) rd_ptr_r <= ~rd_ptr_r;
      count_r   <= count_r + {1'b0, pend_valid_r} - {1'b0, rsp_fire_s};
      credits_r <= credits_r - {1'b0, rd_fire_s} + {1'b0, rsp_fire_s};
    end
  end

`ifdef VX_SP_RAM_ARB_PERF_EN
  logic [31:0] stalls_r;
  logic        multi_s;

  assign multi_s = ((req_valid & (req_valid - NUM_REQS'(1'b1))) != '0);

  // Stall cycle: someone waits ungranted, or several requesters contend
  always_ff @(posedge clk) begin
    if (reset)                                          stalls_r <= 32'd0;
    else if (((|req_valid) && !grant_valid_s) || multi_s) stalls_r <= stalls_r + 32'd1;
  end

  assign perf_stalls = stalls_r;
`else
  assign perf_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_vx_sp_ram_arb.sv
// Directed bench for vx_sp_ram_arb with a response scoreboard and memory model.
module tb_vx_sp_ram_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int WW = 4;
  localparam int TW = 8;
`ifdef VX_SP_RAM_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid, req_rw, req_ready, rsp_valid, rsp_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*WW-1:0] req_wren;
  logic [N*DW-1:0] req_data;
  logic [N*TW-1:0] req_tag;
  logic [DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic [31:0]   perf_stalls;

  vx_sp_ram_arb dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_wren(req_wren), .req_data(req_data), .req_tag(req_tag),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_ready(rsp_ready), .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [7:0]  tag;
    logic [31:0] data;
    bit          chk;
    int          gcyc;
  } exp_t;

  exp_t        exp_q[$];
  int          grant_log[$];
  logic [31:0] mem_m [256];
  bit          mem_v [256];
  int vectors = 0, errors = 0, cyc = 0, exp_stalls = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(input int i, input bit v, input bit rw, input logic [7:0] a,
                       input logic [3:0] w, input logic [31:0] d, input logic [7:0] t);
    req_valid[i]          = v;
    req_rw[i]             = rw;
    req_addr[i*AW +: AW]  = a;
    req_wren[i*WW +: WW]  = w;
    req_data[i*DW +: DW]  = d;
    req_tag[i*TW +: TW]   = t;
  endtask

  task automatic wait_rsp(input int maxc);
    bit got;
    got = 1'b0;
    for (int k = 0; k < maxc && !got; k++) begin
      step();
      smp();
      if (rsp_valid != '0) got = 1'b1;
    end
    check("wait_rsp_timeout", 64'(got), 64'd1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard: record grants, model the RAM, match responses in grant order
  initial begin : monitor
    exp_t e;
    int   g;
    logic [7:0] a;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        for (int i = 0; i < 256; i++) mem_v[i] = 1'b0;
      end else begin
        if ((rsp_valid & rsp_ready) != '0) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_valid_bit", 64'(rsp_valid), 64'(4'b0001 << e.idx));
            check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
            if (e.chk) check("rsp_data", 64'(rsp_data), 64'(e.data));
            check("rsp_latency", 64'(cyc - e.gcyc >= 2), 64'd1);
          end
        end
        if (req_ready != '0) begin
          check("grant_onehot", 64'($onehot(req_ready)), 64'd1);
          check("grant_to_valid", 64'(req_ready & ~req_valid), 64'd0);
          g = 0;
          for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
          grant_log.push_back(g);
          a = req_addr[g*AW +: AW];
          if (req_rw[g]) begin
            for (int l = 0; l < WW; l++)
              if (req_wren[g*WW + l]) mem_m[a][l*8 +: 8] = req_data[g*DW + l*8 +: 8];
            if (req_wren[g*WW +: WW] == 4'hF) mem_v[a] = 1'b1;
          end else begin
            e.idx  = g;
            e.tag  = req_tag[g*TW +: TW];
            e.data = mem_m[a];
            e.chk  = mem_v[a];
            e.gcyc = cyc;
            exp_q.push_back(e);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int gstart, ng;
    reset = 1'b1; req_valid = '0; req_rw = '0; req_addr = '0;
    req_wren = '0; req_data = '0; req_tag = '0; rsp_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b0, 8'd5, 4'hF, 32'd0, 8'h01);
    smp();
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_data", 64'(rsp_data), 64'd0);
    check("reset_rsp_tag", 64'(rsp_tag), 64'd0);
    check("reset_perf", 64'(perf_stalls), 64'd0);
    step(); reset = 1'b0; req_valid = '0;
    smp();

    // single write then read, exact two-cycle latency
    step(); drive(0, 1'b1, 1'b1, 8'd5, 4'hF, 32'hDEADBEEF, 8'h11); smp();
    check("s1_wr_grant", 64'(req_ready), 64'b0001);
    step(); drive(0, 1'b1, 1'b0, 8'd5, 4'hF, 32'd0, 8'h5A); smp();
    check("s1_rd_grant", 64'(req_ready), 64'b0001);
    step(); req_valid = '0; smp();
    check("s1_rsp_early", 64'(rsp_valid), 64'd0);
    step(); smp();
    check("s1_rsp_valid", 64'(rsp_valid), 64'b0001);
    check("s1_rsp_data", 64'(rsp_data), 64'hDEADBEEF);
    check("s1_rsp_tag", 64'(rsp_tag), 64'h5A);
    check("s1_perf", 64'(perf_stalls), 64'd0);

    // byte enables
    step(); drive(1, 1'b1, 1'b1, 8'd9, 4'hF, 32'h11223344, 8'h31); smp();
    check("s2_wr1_grant", 64'(req_ready), 64'b0010);
    step(); drive(1, 1'b1, 1'b1, 8'd9, 4'b0101, 32'hAABBCCDD, 8'h32); smp();
    check("s2_wr2_grant", 64'(req_ready), 64'b0010);
    step(); drive(1, 1'b1, 1'b0, 8'd9, 4'hF, 32'd0, 8'h33); smp();
    check("s2_rd_grant", 64'(req_ready), 64'b0010);
    step(); req_valid = '0;
    wait_rsp(4);
    check("s2_byte_en_data", 64'(rsp_data), 64'h11BB33DD);
    check("s2_rsp_valid", 64'(rsp_valid), 64'b0010);

    // fairness: req 3 writes (pointer then wraps to 0), all four then read
    step(); drive(3, 1'b1, 1'b1, 8'd7, 4'hF, 32'hC0FFEE01, 8'h40); smp();
    check("s3_wr_grant", 64'(req_ready), 64'b1000);
    gstart = grant_log.size();
    for (int c = 0; c < 8; c++) begin
      step();
      for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b0, 8'd7, 4'hF, 32'd0, 8'(8'h50 + i));
      smp();
    end
    exp_stalls += 8;
    step(); req_valid = '0; smp();
    repeat (6) begin step(); smp(); end
    check("s3_grant_count", 64'(grant_log.size() - gstart), 64'd6);
    for (int k = 0; k < 6 && gstart + k < grant_log.size(); k++)
      check("s3_grant_order", 64'(grant_log[gstart + k]), 64'(k % 4));
    check("s3_drained", 64'(exp_q.size()), 64'd0);
    check("s3_perf", 64'(perf_stalls), PERF ? 64'(exp_stalls) : 64'd0);

    // backpressure: two credits only
    rsp_ready = '0;
    ng = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      drive(2, 1'b1, 1'b0, (ng % 2 == 1) ? 8'd9 : 8'd5, 4'hF, 32'd0, 8'(8'h21 + ng));
      smp();
      if (req_ready[2]) ng++;
    end
    exp_stalls += 4;
    check("s4_two_grants", 64'(ng), 64'd2);
    check("s4_hold_valid", 64'(rsp_valid), 64'b0100);
    check("s4_hold_tag", 64'(rsp_tag), 64'h21);
    step(); rsp_ready = '1; smp();
    exp_stalls += 1;
    check("s4_no_grant_at_fire", 64'(req_ready), 64'd0);
    check("s4_fire_valid", 64'(rsp_valid), 64'b0100);
    step(); smp();
    check("s4_third_grant", 64'(req_ready), 64'b0100);
    step(); req_valid = '0; smp();
    repeat (5) begin step(); smp(); end
    check("s4_drained", 64'(exp_q.size()), 64'd0);
    check("s4_perf", 64'(perf_stalls), PERF ? 64'(exp_stalls) : 64'd0);

    // writes still granted with credits exhausted
    rsp_ready = '0;
    step(); drive(2, 1'b1, 1'b0, 8'd5, 4'hF, 32'd0, 8'h61); smp();
    check("s5_rd1_grant", 64'(req_ready), 64'b0100);
    step(); drive(2, 1'b1, 1'b0, 8'd5, 4'hF, 32'd0, 8'h62); smp();
    check("s5_rd2_grant", 64'(req_ready), 64'b0100);
    step(); drive(2, 1'b1, 1'b0, 8'd9, 4'hF, 32'd0, 8'h63);
    drive(1, 1'b1, 1'b1, 8'd12, 4'hF, 32'h0BADF00D, 8'h70); smp();
    check("s5_wr1_granted", 64'(req_ready), 64'b0010);
    step(); drive(1, 1'b1, 1'b1, 8'd12, 4'b0011, 32'h12345678, 8'h71); smp();
    check("s5_wr2_granted", 64'(req_ready), 64'b0010);
    step(); req_valid[1] = 1'b0; smp();
    check("s5_read_waits", 64'(req_ready), 64'd0);
    exp_stalls += 3;
    check("s5_perf", 64'(perf_stalls), PERF ? 64'(exp_stalls) : 64'd0);
    step(); rsp_ready = '1; smp();
    exp_stalls += 1;
    check("s5_stall_at_fire", 64'(req_ready), 64'd0);
    step(); smp();
    check("s5_rd3_grant", 64'(req_ready), 64'b0100);
    step(); req_valid = '0; smp();
    repeat (5) begin step(); smp(); end
    step(); drive(0, 1'b1, 1'b0, 8'd12, 4'hF, 32'd0, 8'h7E); smp();
    check("s5_rdback_grant", 64'(req_ready), 64'b0001);
    step(); req_valid = '0;
    wait_rsp(4);
    check("s5_rdback_data", 64'(rsp_data), 64'h0BAD5678);
    check("s5_perf_end", 64'(perf_stalls), PERF ? 64'(exp_stalls) : 64'd0);

    // reset one cycle after a read grant
    step(); drive(0, 1'b1, 1'b0, 8'd5, 4'hF, 32'd0, 8'h77); smp();
    check("s6_rd_grant", 64'(req_ready), 64'b0001);
    step(); req_valid = '0; reset = 1'b1; smp();
    step(); reset = 1'b0; smp();
    exp_stalls = 0;
    check("s6_perf_cleared", 64'(perf_stalls), 64'd0);
    repeat (4) begin
      step(); smp();
      check("s6_no_rsp", 64'(rsp_valid), 64'd0);
    end
    step();
    for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b0, 8'd5, 4'hF, 32'd0, 8'(8'h80 + i));
    smp();
    check("s6_first_grant_req0", 64'(req_ready), 64'b0001);
    step(); smp();
    check("s6_second_grant_req1", 64'(req_ready), 64'b0010);
    step(); smp();
    check("s6_credit_cap", 64'(req_ready), 64'd0);
    exp_stalls += 3;
    step(); req_valid = '0; smp();
    repeat (6) begin step(); smp(); end
    check("s6_drained", 64'(exp_q.size()), 64'd0);
    check("s6_perf", 64'(perf_stalls), PERF ? 64'(exp_stalls) : 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
